// File: rtl/rpg_readback_tx.sv
// Readback transmitter for the reprogram link: streams a block of program-memory
// words out as 8N1 UART bytes (LSB byte first), followed by an XOR checksum byte.
module rpg_readback_tx #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 13
) (
  input  logic              clk_50mhz,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_data,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic [7:0]        xorc
);

  localparam int DIVISOR = CLK_HZ / BAUD;
  localparam int CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0]  BAUD_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]   WORD_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, BYTE, CHECK, FINISH} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  baudCnt_q, baudCnt_d;
  logic [3:0]        bitIdx_q, bitIdx_d;
  logic [1:0]        byteIdx_q, byteIdx_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   wordCnt_q, wordCnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        xorc_q, xorc_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [7:0] curByte;
  logic       bitEnd;
  logic       frameEnd;

  always_ff @(posedge clk_50mhz or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      baudCnt_q <= '0;
      bitIdx_q  <= '0;
      byteIdx_q <= '0;
      word_q    <= '0;
      count_q   <= '0;
      wordCnt_q <= '0;
      addr_q    <= '0;
      xorc_q    <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baudCnt_q <= baudCnt_d;
      bitIdx_q  <= bitIdx_d;
      byteIdx_q <= byteIdx_d;
      word_q    <= word_d;
      count_q   <= count_d;
      wordCnt_q <= wordCnt_d;
      addr_q    <= addr_d;
      xorc_q    <= xorc_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // tx is registered, so the line trails the frame counters by one cycle.
  always_comb begin
    curByte   = (state_q == CHECK) ? xorc_q : word_q[8*byteIdx_q +: 8];
    bitEnd    = (baudCnt_q == BAUD_LAST);
    frameEnd  = bitEnd && (bitIdx_q == 4'd9);
    state_d   = state_q;
    baudCnt_d = baudCnt_q;
    bitIdx_d  = bitIdx_q;
    byteIdx_d = byteIdx_q;
    word_d    = word_q;
    count_d   = count_q;
    wordCnt_d = wordCnt_q;
    addr_d    = addr_q;
    xorc_d    = xorc_q;
    tx_d      = 1'b1;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          count_d   = count;
          addr_d    = '0;
          wordCnt_d = '0;
          xorc_d    = '0;
          busy_d    = 1'b1;
          baudCnt_d = '0;
          bitIdx_d  = '0;
          state_d   = (count != '0) ? FETCH : CHECK;
        end
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        word_d    = mem_data;
        byteIdx_d = '0;
        baudCnt_d = '0;
        bitIdx_d  = '0;
        state_d   = BYTE;
      end
      BYTE, CHECK: begin
        if (bitIdx_q == 4'd0) begin
          tx_d = 1'b0;
        end else if (bitIdx_q == 4'd9) begin
          tx_d = 1'b1;
        end else begin
          tx_d = curByte[3'(bitIdx_q - 4'd1)];
        end
        if (state_q == BYTE && bitIdx_q == 4'd0 && baudCnt_q == '0) begin
          xorc_d = xorc_q ^ curByte;
        end
        baudCnt_d = bitEnd ? '0 : baudCnt_q + BAUD_ONE;
        if (bitEnd) begin
          bitIdx_d = bitIdx_q + 4'd1;
        end
        // The last-word test uses the word counter so a full 2^ADDR_W block works.
        if (frameEnd) begin
          bitIdx_d = '0;
          if (state_q == CHECK) begin
            state_d = FINISH;
          end else if (byteIdx_q != 2'd3) begin
            byteIdx_d = byteIdx_q + 2'd1;
          end else if (wordCnt_q + WORD_ONE == count_q) begin
            state_d = CHECK;
          end else begin
            wordCnt_d = wordCnt_q + WORD_ONE;
            addr_d    = addr_q + ADDR_ONE;
            state_d   = FETCH;
          end
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr = addr_q;
  assign mem_rd   = (state_q == FETCH);
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign xorc     = xorc_q;

endmodule

// File: tb/tb_rpg_readback_tx.sv
// Bench for rpg_readback_tx: records the tx line per cycle, decodes it as a UART
// receiver would, and compares against bytes and timing derived from memory contents.
module tb_rpg_readback_tx;

  // 50 MHz / 7 Mbaud truncates to 7 clocks per bit
  localparam int DIV   = 7;
  localparam int FRAME = 10 * DIV;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [3:0]  count;
  logic [2:0]  memAddr;
  logic        memRd;
  logic [31:0] memData;
  logic        tx;
  logic        busy;
  logic        done;
  logic [7:0]  xorc;

  logic [31:0] memArr [8];

  int checks = 0;
  int errors = 0;

  logic txQ [$];
  logic busyQ [$];
  logic doneQ [$];
  logic rdQ [$];
  int   addrQ [$];

  typedef struct {
    int          cnt;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  expXor;
  } vec_t;

  vec_t vecs [6];

  rpg_readback_tx #(
    .CLK_HZ(50000000),
    .BAUD  (7000000),
    .ADDR_W(3)
  ) dut (
    .clk_50mhz(clk),
    .rstn     (rstn),
    .start    (start),
    .count    (count),
    .mem_addr (memAddr),
    .mem_rd   (memRd),
    .mem_data (memData),
    .tx       (tx),
    .busy     (busy),
    .done     (done),
    .xorc     (xorc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: data valid the cycle after a read, garbage otherwise
  always @(posedge clk) begin
    memData <= memRd ? memArr[memAddr] : $urandom();
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic recordSample();
    txQ.push_back(tx);
    busyQ.push_back(busy);
    doneQ.push_back(done);
    rdQ.push_back(memRd);
    addrQ.push_back(int'(memAddr));
  endtask

  // Sample k of the trace is taken 1 ns after the k-th edge following the start edge
  task automatic applyStimulus(input int cnt, input int injectAt, input int injectCnt);
    bit seen;
    int extra;
    txQ.delete();
    busyQ.delete();
    doneQ.delete();
    rdQ.delete();
    addrQ.delete();
    @(negedge clk);
    count = 4'(cnt);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    count = 4'($urandom_range(0, 8));
    recordSample();
    seen  = 1'b0;
    extra = 0;
    for (int k = 1; k < 4000 && extra < 4; k++) begin
      if (k == injectAt) begin
        start = 1'b1;
        count = 4'(injectCnt);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      recordSample();
      if (seen) extra++;
      if (done) seen = 1'b1;
    end
    checkOutput("doneSeen", 32'(seen), 32'd1);
  endtask

  task automatic analyze(input int cnt, output logic [7:0] modelXor);
    logic [7:0] expBytes [$];
    int         expStarts [$];
    logic [7:0] gotBytes [$];
    int         gotStarts [$];
    int         timingErr, startErr, busyErr, addrErr, rdCnt, doneCnt, doneIdx, i;
    logic [7:0] b;
    logic       lvl;

    modelXor = 8'h00;
    for (int w = 0; w < cnt; w++) begin
      for (int j = 0; j < 4; j++) begin
        b = memArr[w][8*j +: 8];
        expBytes.push_back(b);
        expStarts.push_back(3 + (4*w + j) * FRAME + 2*w);
        modelXor ^= b;
      end
    end
    expBytes.push_back(modelXor);
    expStarts.push_back(3 + 4*cnt*FRAME + 2*(cnt - 1));

    timingErr = 0;
    i = 0;
    while (i < txQ.size()) begin
      if (txQ[i] == 1'b0) begin
        if (i + FRAME > txQ.size()) begin
          timingErr++;
          break;
        end
        b = 8'h00;
        for (int bit_n = 0; bit_n < 10; bit_n++) begin
          lvl = txQ[i + bit_n*DIV];
          for (int s = 1; s < DIV; s++) begin
            if (txQ[i + bit_n*DIV + s] !== lvl) timingErr++;
          end
          if (bit_n >= 1 && bit_n <= 8) b[bit_n-1] = lvl;
          if (bit_n == 9 && lvl !== 1'b1) timingErr++;
        end
        gotBytes.push_back(b);
        gotStarts.push_back(i);
        i += FRAME;
      end else begin
        i++;
      end
    end

    checkOutput("frameCount", 32'(gotBytes.size()), 32'(expBytes.size()));
    for (int j = 0; j < gotBytes.size() && j < expBytes.size(); j++) begin
      checkOutput($sformatf("byte%0d", j), 32'(gotBytes[j]), 32'(expBytes[j]));
    end
    checkOutput("bitTiming", 32'(timingErr), 32'd0);

    if (cnt > 0) begin
      startErr = 0;
      for (int j = 0; j < gotStarts.size() && j < expStarts.size(); j++) begin
        if (gotStarts[j] != expStarts[j]) startErr++;
      end
      checkOutput("frameStarts", 32'(startErr), 32'd0);
      if (gotStarts.size() > 0) checkOutput("firstStart", 32'(gotStarts[0]), 32'd3);
    end

    doneCnt = 0;
    doneIdx = -1;
    for (int k = 0; k < doneQ.size(); k++) begin
      if (doneQ[k] === 1'b1) begin
        doneCnt++;
        if (doneIdx < 0) doneIdx = k;
      end
    end
    checkOutput("donePulses", 32'(doneCnt), 32'd1);
    if (gotStarts.size() > 0) begin
      checkOutput("doneIdx", 32'(doneIdx), 32'(gotStarts[gotStarts.size()-1] + FRAME));
    end

    busyErr = 0;
    for (int k = 0; k < busyQ.size(); k++) begin
      if (busyQ[k] !== ((doneIdx < 0) || (k < doneIdx))) busyErr++;
    end
    checkOutput("busyWindow", 32'(busyErr), 32'd0);

    rdCnt   = 0;
    addrErr = 0;
    for (int k = 0; k < rdQ.size(); k++) begin
      if (rdQ[k] === 1'b1) begin
        if (addrQ[k] != rdCnt) addrErr++;
        rdCnt++;
      end
    end
    checkOutput("rdPulses", 32'(rdCnt), 32'(cnt));
    checkOutput("rdAddr", 32'(addrErr), 32'd0);
    checkOutput("xorcFinal", 32'(xorc), 32'(modelXor));
    checkOutput("finalAddr", 32'(memAddr), 32'((cnt > 0) ? cnt - 1 : 0));
  endtask

  task automatic fillRandomMem();
    for (int a = 0; a < 8; a++) memArr[a] = $urandom();
  endtask

  initial begin
    logic [7:0] mx;

    vecs[0] = '{cnt: 1, w0: 32'h12345678, w1: 32'h0,        expXor: 8'h08};
    vecs[1] = '{cnt: 0, w0: 32'h0,        w1: 32'h0,        expXor: 8'h00};
    vecs[2] = '{cnt: 2, w0: 32'hFFFFFFFF, w1: 32'h000000A5, expXor: 8'hA5};
    vecs[3] = '{cnt: 1, w0: 32'hA5A5A5A5, w1: 32'h0,        expXor: 8'h00};
    vecs[4] = '{cnt: 1, w0: 32'h000000FF, w1: 32'h0,        expXor: 8'hFF};
    vecs[5] = '{cnt: 2, w0: 32'h01020304, w1: 32'h10203040, expXor: 8'h44};

    rstn  = 1'b0;
    start = 1'b0;
    count = 4'd0;
    for (int a = 0; a < 8; a++) memArr[a] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstTx", 32'(tx), 32'd1);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstRd", 32'(memRd), 32'd0);
    checkOutput("rstAddr", 32'(memAddr), 32'd0);
    checkOutput("rstXorc", 32'(xorc), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    for (int v = 0; v < 6; v++) begin
      fillRandomMem();
      memArr[0] = vecs[v].w0;
      memArr[1] = vecs[v].w1;
      applyStimulus(vecs[v].cnt, -1, 0);
      analyze(vecs[v].cnt, mx);
      checkOutput($sformatf("tableXor%0d", v), 32'(xorc), 32'(vecs[v].expXor));
    end

    // Full address range: all eight words, no ninth fetch
    fillRandomMem();
    applyStimulus(8, -1, 0);
    analyze(8, mx);

    // Start mid-transfer with a different count must be ignored
    fillRandomMem();
    applyStimulus(1, 40, 8);
    analyze(1, mx);

    // Start landing in the FINISH cycle (two words: done at 3+8*70+2+70) must be ignored
    fillRandomMem();
    applyStimulus(2, 635, 3);
    analyze(2, mx);

    // Asynchronous reset during a zero data bit
    memArr[0] = 32'h0;
    @(negedge clk);
    count = 4'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("preRstTx", 32'(tx), 32'd0);
    checkOutput("preRstBusy", 32'(busy), 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    checkOutput("midRstTx", 32'(tx), 32'd1);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstAddr", 32'(memAddr), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    fillRandomMem();
    applyStimulus(1, -1, 0);
    analyze(1, mx);

    for (int r = 0; r < 10; r++) begin
      int c;
      fillRandomMem();
      c = $urandom_range(0, 8);
      applyStimulus(c, -1, 0);
      analyze(c, mx);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rpg_readback_tx.md
Name: rpg_readback_tx

Overview:
UART transmitter for the reprogram link, driving the RPG_TX pin. On a start pulse it reads a block of 32-bit words from the program memory port and serialises each word as 4 bytes, least-significant byte first. After the last word it sends one XOR checksum byte, matching the xorc convention the receive path computes. This lets the host read back and verify what was written.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
BAUD, 115200, line rate; DIVISOR = CLK_HZ/BAUD, integer-truncated (434 at defaults)
ADDR_W, 13, memory word-address width

Ports:
clk_50mhz  input  1  system clock, all logic on rising edge
rstn  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a readback; ignored while busy=1
count  input  ADDR_W+1  number of words to send (0..2^ADDR_W), sampled on start
mem_addr  output  ADDR_W  word address to program memory
mem_rd  output  1  read strobe; mem_data is valid on the cycle after mem_rd=1
mem_data  input  32  read data from program memory
tx  output  1  UART serial out; idle high
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse after the checksum stop bit completes
xorc  output  8  running XOR of all data bytes sent in the current transfer

Behaviour:
- Reset (asynchronous, immediate, effective at any time including mid-frame): tx=1, busy=0, done=0, mem_rd=0, mem_addr=0, xorc=0, FSM in IDLE, baud counter=0.
- Line format: 8N1. Start bit 0, data bits LSB first, stop bit 1. Each bit is held for exactly DIVISOR clocks, so one byte frame = 10*DIVISOR clocks.
- FSM states: IDLE, FETCH, LATCH, BYTE, CHECK, FINISH.
- IDLE: tx=1. If start=1 at edge N: latch count, mem_addr=0, xorc=0, busy=1. Go to FETCH if count!=0, otherwise go to CHECK.
- FETCH (1 cycle): mem_rd=1 with the current mem_addr. Go to LATCH.
- LATCH (1 cycle): capture mem_data into the shift word, byte index=0. Go to BYTE.
- Start-bit timing: from start at edge N, the first start bit (tx=0) begins at edge N+3.
- BYTE: transmit byte[index] of the word. When the byte's first bit begins, update xorc ^= byte.
  - After the stop bit: if index<3, increment index and start the next byte with no idle gap.
  - If index==3 and this was not the last word: mem_addr++ and go to FETCH. This leaves a 2-cycle tx=1 gap between words.
  - If index==3 and this was the last word: go to CHECK.
- Last-word test: compare the word counter to the latched count. Do not compare mem_addr. This is required so that count=2^ADDR_W sends every address; mem_addr wraps to 0 and is not used afterwards.
- CHECK: transmit the final xorc value as one frame. xorc is not updated by this byte. Then go to FINISH.
- FINISH (1 cycle): done=1, busy=0, return to IDLE. xorc holds its value until the next start.
- start while busy=1: ignored. A start asserted in the FINISH cycle is also ignored.
- A change on count or mem_data outside the LATCH/start sampling points has no effect.
- Baud counter counts 0..DIVISOR-1. It resets to 0 at every bit boundary and on every frame start.

Test Plan:
- Single word: count=1, mem[0]=0x12345678, start.
  - Bytes on tx, in order: 0x78, 0x56, 0x34, 0x12, checksum 0x08.
  - Every bit is 434 clocks long.
  - First start bit begins 3 cycles after start; done pulses once, 1 cycle after the final stop bit.
  - busy=1 for the whole transfer.
- Empty transfer: count=0 -> exactly one frame with byte 0x00, no mem_rd pulses, done=1, xorc=0.
- Two words: mem[0]=0xFFFFFFFF, mem[1]=0x000000A5, count=2.
  - Bytes: FF FF FF FF A5 00 00 00, checksum 0xA5.
  - mem_addr sequence 0 then 1.
  - Exactly 2 tx=1 idle cycles between byte 3 and byte 4.
- Start while busy: second start pulse mid-transfer -> no change to the byte stream, a single done pulse, count not re-latched.
- Reset mid-frame: deassert rstn during a data bit -> tx=1 and busy=0 in the same cycle, without waiting for a clock edge. After release, a new start with count=1 sends a clean 5-frame sequence.
- Full range: ADDR_W=3, count=8 -> 32 data bytes from addresses 0..7, then checksum. No ninth fetch; mem_addr ends at 7.
